// File: rtl/serial_frame_encoder_pkg.sv
// serial_pkg: shared state type, default sync byte and sizing helper for the serial frame encoder/decoder.
// The CSUM state exists only when SERIAL_FRAME_CHECKSUM_EN is defined.
package serial_pkg;
    typedef enum logic [1:0] {
        IDLE,
        SYNC,
`ifdef SERIAL_FRAME_CHECKSUM_EN
        PAYLOAD,
        CSUM
`else
        PAYLOAD
`endif
    } state_t;
    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
    function automatic int bytes_for_bits(input int n);
        return (n + 7) / 8;
    endfunction
endpackage

// File: rtl/serial_frame_encoder_if.sv
// serial_frame_encoder_if: frame input handshake and byte-wide transmit handshake.
interface serial_frame_encoder_if #(parameter int W = 74) ();
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   tx_byte;
    logic         tx_valid;
    logic         tx_ready;
    logic         busy;
    modport master (output in_data, in_valid, tx_ready, input in_ready, tx_byte, tx_valid, busy);
    modport slave  (input in_data, in_valid, tx_ready, output in_ready, tx_byte, tx_valid, busy);
endinterface

// File: rtl/serial_frame_encoder_checksum_acc.sv
// serial_checksum_acc: 8-bit modulo-256 running sum of payload bytes, cleared at frame acceptance.
module serial_checksum_acc (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       add,
    input  logic [7:0] din,
    output logic [7:0] sum
);
    always_ff @(posedge clk)
        if (reset || clear) sum <= 8'h00;
        else if (add) sum <= sum + din;
endmodule

// File: rtl/serial_frame_encoder.sv
// serial_frame_encoder: sync byte + little-endian snapshot of NUM_WORDS signed words onto a byte valid/ready link.
// Optional trailing checksum byte under SERIAL_FRAME_CHECKSUM_EN.
module serial_frame_encoder
    import serial_pkg::*;
#(
    parameter int          WORD_BITS   = 37,
    parameter int          NUM_WORDS   = 2,
    parameter logic [7:0]  SYNC_BYTE   = SYNC_DEFAULT,
    parameter bit          SIGN_EXTEND = 1'b1
) (
    input  logic clk,
    input  logic reset,
    serial_frame_encoder_if.slave bus
);
    localparam int WORD_BYTES    = bytes_for_bits(WORD_BITS);
    localparam int PAYLOAD_BYTES = NUM_WORDS * WORD_BYTES;
    localparam int IDX_BITS      = $clog2(PAYLOAD_BYTES + 1);
    localparam int PW            = WORD_BYTES * 8;

    state_t                       state, next;
    logic [IDX_BITS-1:0]          idx;
    logic [NUM_WORDS*WORD_BITS-1:0] snap;
    logic [PW-1:0]                padded [NUM_WORDS];
    logic [7:0]                   pbytes [PAYLOAD_BYTES];
    logic                         accept, xfer, last;

    assign accept = bus.in_valid && bus.in_ready;
    assign xfer   = bus.tx_valid && bus.tx_ready;
    assign last   = idx == IDX_BITS'(PAYLOAD_BYTES - 1);

    // Words are widened to whole bytes once, so byte selection is a plain mux.
    for (genvar w = 0; w < NUM_WORDS; w++) begin : g_word
        assign padded[w] = SIGN_EXTEND ? PW'($signed(snap[w*WORD_BITS +: WORD_BITS]))
                                       : PW'(snap[w*WORD_BITS +: WORD_BITS]);
    end
    for (genvar i = 0; i < PAYLOAD_BYTES; i++) begin : g_byte
        assign pbytes[i] = padded[i / WORD_BYTES][(i % WORD_BYTES)*8 +: 8];
    end

`ifdef SERIAL_FRAME_CHECKSUM_EN
    logic [7:0] csum;
    serial_checksum_acc u_acc (
        .clk  (clk),
        .reset(reset),
        .clear(accept),
        .add  (xfer && state == PAYLOAD),
        .din  (bus.tx_byte),
        .sum  (csum)
    );
`endif

    always_ff @(posedge clk)
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
            snap  <= '0;
        end else begin
            state <= next;
            if (accept) snap <= bus.in_data;
            if (accept) idx <= '0;
            else if (xfer && state == PAYLOAD && !last) idx <= idx + 1'b1;
        end

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = accept ? SYNC : IDLE;
            SYNC:    next = xfer ? PAYLOAD : SYNC;
`ifdef SERIAL_FRAME_CHECKSUM_EN
            PAYLOAD: next = xfer && last ? CSUM : PAYLOAD;
            CSUM:    next = xfer ? IDLE : CSUM;
`else
            PAYLOAD: next = xfer && last ? IDLE : PAYLOAD;
`endif
            default: next = IDLE;
        endcase
    end

    assign bus.in_ready = state == IDLE;
    assign bus.busy     = state != IDLE;
    assign bus.tx_valid = state != IDLE;
`ifdef SERIAL_FRAME_CHECKSUM_EN
    assign bus.tx_byte  = state == SYNC ? SYNC_BYTE : state == PAYLOAD ? pbytes[idx] : state == CSUM ? csum : 8'h00;
`else
    assign bus.tx_byte  = state == SYNC ? SYNC_BYTE : state == PAYLOAD ? pbytes[idx] : 8'h00;
`endif
endmodule

// File: tb/tb_serial_frame_encoder.sv
// tb_serial_frame_encoder: directed checks of framing, padding, backpressure, snapshotting and reset abort.
module tb_serial_frame_encoder;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    serial_frame_encoder_if #(.W(74)) b1 ();
    serial_frame_encoder_if #(.W(74)) b2 ();

    serial_frame_encoder #(.WORD_BITS(37), .NUM_WORDS(2), .SYNC_BYTE(8'hA5), .SIGN_EXTEND(1'b1))
        dut (.clk(clk), .reset(reset), .bus(b1));
    serial_frame_encoder #(.WORD_BITS(37), .NUM_WORDS(2), .SYNC_BYTE(8'hA5), .SIGN_EXTEND(1'b0))
        dut_zp (.clk(clk), .reset(reset), .bus(b2));

    localparam logic [73:0] D0 = {37'h0_1234_5678, 37'h1F_FFFF_FFFF};
    localparam logic [73:0] D1 = {37'h0_0BAD_CAFE, 37'h0_0000_0001};
`ifdef SERIAL_FRAME_CHECKSUM_EN
    localparam int N = 12;
`else
    localparam int N = 11;
`endif
    logic [7:0] exp1 [12] = '{8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h78, 8'h56, 8'h34, 8'h12, 8'h00, 8'h0F};
    logic [7:0] exp2 [12] = '{8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h1F, 8'h78, 8'h56, 8'h34, 8'h12, 8'h00, 8'h2F};

    int checks = 0;
    int errors = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [73:0] d);
        int t = 0;
        while (!b1.in_ready && t < 50) begin
            tick();
            t++;
        end
        checks++;
        if (b1.in_ready !== 1'b1) begin
            $display("FAIL start: in_ready=%b want 1", b1.in_ready);
            errors++;
        end
        b1.in_data  = d;
        b1.in_valid = 1'b1;
        tick();
        b1.in_valid = 1'b0;
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (b1.tx_valid !== 1'b0 || b1.in_ready !== 1'b1 || b1.busy !== 1'b0) begin
            $display("FAIL %s: tx_valid=%b in_ready=%b busy=%b want 0 1 0", name, b1.tx_valid, b1.in_ready, b1.busy);
            errors++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        b1.in_valid = 1'b0; b1.in_data = '0; b1.tx_ready = 1'b0;
        b2.in_valid = 1'b0; b2.in_data = '0; b2.tx_ready = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        check_idle("reset");
        checks++;
        if (b1.tx_byte !== 8'h00) begin
            $display("FAIL reset_tx_byte: got %h want 00", b1.tx_byte);
            errors++;
        end
    endtask

    task automatic test_sign_extend;
        b1.tx_ready = 1'b1;
        start(D0);
        for (int k = 0; k < N; k++) begin
            checks++;
            if (b1.tx_valid !== 1'b1 || b1.tx_byte !== exp1[k]) begin
                $display("FAIL sign_ext byte %0d: valid=%b got %h want %h", k, b1.tx_valid, b1.tx_byte, exp1[k]);
                errors++;
            end
            tick();
        end
        check_idle("sign_ext_end");
    endtask

    task automatic test_zero_pad;
        b2.in_data  = D0;
        b2.in_valid = 1'b1;
        tick();
        b2.in_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            checks++;
            if (b2.tx_valid !== 1'b1 || b2.tx_byte !== exp2[k]) begin
                $display("FAIL zero_pad byte %0d: valid=%b got %h want %h", k, b2.tx_valid, b2.tx_byte, exp2[k]);
                errors++;
            end
            tick();
        end
        checks++;
        if (b2.tx_valid !== 1'b0 || b2.in_ready !== 1'b1) begin
            $display("FAIL zero_pad_end: tx_valid=%b in_ready=%b want 0 1", b2.tx_valid, b2.in_ready);
            errors++;
        end
    endtask

    task automatic test_backpressure;
        int cnt = 0;
        int cyc = 0;
        logic pv = 1'b0;
        logic pr = 1'b0;
        logic [7:0] pb = 8'h00;
        b1.tx_ready = 1'b0;
        start(D0);
        while (cnt < N && cyc < 400) begin
            if (pv && !pr) begin
                checks++;
                if (b1.tx_valid !== 1'b1 || b1.tx_byte !== pb) begin
                    $display("FAIL bp_stable: valid=%b got %h want %h", b1.tx_valid, b1.tx_byte, pb);
                    errors++;
                end
            end
            pv = b1.tx_valid;
            pb = b1.tx_byte;
            pr = $urandom_range(0, 99) < 30;
            b1.tx_ready = pr;
            if (pv && pr) begin
                checks++;
                if (pb !== exp1[cnt]) begin
                    $display("FAIL bp_byte %0d: got %h want %h", cnt, pb, exp1[cnt]);
                    errors++;
                end
                cnt++;
            end
            tick();
            cyc++;
        end
        checks++;
        if (cnt != N) begin
            $display("FAIL bp_timeout: transferred %0d want %0d", cnt, N);
            errors++;
        end
        b1.tx_ready = 1'b1;
        check_idle("bp_end");
    endtask

    task automatic test_snapshot;
        b1.tx_ready = 1'b1;
        start(D0);
        for (int k = 0; k < N; k++) begin
            checks++;
            if (b1.tx_valid !== 1'b1 || b1.tx_byte !== exp1[k]) begin
                $display("FAIL snapshot byte %0d: valid=%b got %h want %h", k, b1.tx_valid, b1.tx_byte, exp1[k]);
                errors++;
            end
            b1.in_data  = k >= 3 ? D1 : D0;
            b1.in_valid = k == 3;
            tick();
        end
        b1.in_valid = 1'b0;
        check_idle("snapshot_end");
        repeat (2) tick();
        check_idle("no_second_frame");
    endtask

    task automatic test_reset_mid_frame;
        b1.tx_ready = 1'b1;
        start(D0);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle("reset_abort");
        start(D0);
        checks++;
        if (b1.tx_valid !== 1'b1 || b1.tx_byte !== 8'hA5) begin
            $display("FAIL after_reset_sync: valid=%b got %h want A5", b1.tx_valid, b1.tx_byte);
            errors++;
        end
        tick();
        checks++;
        if (b1.tx_byte !== 8'hFF) begin
            $display("FAIL after_reset_byte0: got %h want FF", b1.tx_byte);
            errors++;
        end
        repeat (N - 1) tick();
        check_idle("after_reset_end");
    endtask

    initial begin
        test_reset();
        test_sign_extend();
        test_zero_pad();
        test_backpressure();
        test_snapshot();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
